// File: rtl/spi_xfer_engine_if.sv
// Request/response and SPI pin bundle for spi_xfer_engine.
// `SPI_RX_BYTE_REV_EN adds the rev_i request field.
interface spi_xfer_engine_if #(
    parameter int MAX_BYTES = 4,
    parameter int NUM_CS    = 4,
    parameter int LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
    parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [7:0]             div_i;
    logic                   cpol_i;
    logic                   cpha_i;
    logic                   lsb_i;
    logic [LEN_W-1:0]       nbytes_i;
    logic [CS_W-1:0]        cs_sel_i;
    logic [8*MAX_BYTES-1:0] tx_data_i;
`ifdef SPI_RX_BYTE_REV_EN
    logic                   rev_i;
`endif
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [8*MAX_BYTES-1:0] rx_data_o;
    logic                   busy_o;
    logic                   spi_sck_o;
    logic [NUM_CS-1:0]      spi_nss_o;
    logic                   spi_mosi_o;
    logic                   spi_miso_i;

    modport master (
`ifdef SPI_RX_BYTE_REV_EN
        output rev_i,
`endif
        output req_valid_i, div_i, cpol_i, cpha_i, lsb_i, nbytes_i, cs_sel_i,
        output tx_data_i, rsp_ready_i, spi_miso_i,
        input  req_ready_o, rsp_valid_o, rx_data_o, busy_o,
        input  spi_sck_o, spi_nss_o, spi_mosi_o
    );

    modport slave (
`ifdef SPI_RX_BYTE_REV_EN
        input  rev_i,
`endif
        input  req_valid_i, div_i, cpol_i, cpha_i, lsb_i, nbytes_i, cs_sel_i,
        input  tx_data_i, rsp_ready_i, spi_miso_i,
        output req_ready_o, rsp_valid_o, rx_data_o, busy_o,
        output spi_sck_o, spi_nss_o, spi_mosi_o
    );
endinterface

// File: rtl/spi_xfer_engine.sv
// SPI master shift engine: one 1..MAX_BYTES byte full-duplex transfer per request.
// `SPI_RX_BYTE_REV_EN enables rev_i, which reverses the received active bytes.
module spi_xfer_engine #(
    parameter int MAX_BYTES = 4,
    parameter int NUM_CS    = 4,
    parameter int LEN_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
    parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input logic              clk_i,
    input logic              rst_i,
    spi_xfer_engine_if.slave bus
);
    localparam int DW    = 8 * MAX_BYTES;
    localparam int PW    = $clog2(DW);
    localparam int BIT_W = $clog2(DW + 1);
    localparam int HW    = BIT_W + 1;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, RESP} state_t;

    state_t            state_q;
    logic [7:0]        div_q, hp_q;
    logic              cpha_q, lsb_q;
    logic [LEN_W-1:0]  nb_q;
    logic [DW-1:0]     tx_q, rx_q, rx_out_q;
    logic [HW-1:0]     half_q;
    logic              req_ready_q, rsp_valid_q, busy_q, sck_q, mosi_q;
    logic [NUM_CS-1:0] nss_q;
`ifdef SPI_RX_BYTE_REV_EN
    logic              rev_q;
`endif

    logic [LEN_W-1:0]  nb_in;
    logic [BIT_W-1:0]  nbits, nbits_in, bidx, bnext;
    logic [NUM_CS-1:0] nss_sel;
    logic              first_bit, hp_end, lead_edge, last_half;
    logic [DW-1:0]     rx_final;

    // Bit i of the serial stream maps to vector position i (LSB-first) or n-1-i.
    function automatic logic [PW-1:0] bit_pos(input logic lsb, input logic [BIT_W-1:0] n,
                                              input logic [BIT_W-1:0] i);
        return lsb ? PW'(i) : PW'(n - i - BIT_W'(1));
    endfunction

    always_comb begin
        nb_in = bus.nbytes_i;
        if (32'(bus.nbytes_i) >= 32'(MAX_BYTES))
            nb_in = LEN_W'(MAX_BYTES - 1);
        nbits_in  = (BIT_W'(nb_in) + BIT_W'(1)) << 3;
        nbits     = (BIT_W'(nb_q) + BIT_W'(1)) << 3;
        first_bit = bus.tx_data_i[bit_pos(bus.lsb_i, nbits_in, '0)];
        bidx      = BIT_W'(half_q >> 1);
        bnext     = bidx + BIT_W'(1);
        hp_end    = (hp_q == 8'd0);
        lead_edge = ~half_q[0];
        last_half = (half_q == ({nbits, 1'b0} - HW'(1)));
        for (int unsigned i = 0; i < NUM_CS; i++)
            nss_sel[i] = (32'(bus.cs_sel_i) != i);
    end

`ifdef SPI_RX_BYTE_REV_EN
    always_comb begin
        rx_final = rx_q;
        if (rev_q) begin
            rx_final = '0;
            for (int unsigned k = 0; k < MAX_BYTES; k++)
                if (k <= 32'(nb_q))
                    rx_final[8*(32'(nb_q)-k) +: 8] = rx_q[8*k +: 8];
        end
    end
`else
    always_comb rx_final = rx_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            hp_q        <= '0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            nb_q        <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rx_out_q    <= '0;
            half_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            nss_q       <= '1;
`ifdef SPI_RX_BYTE_REV_EN
            rev_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid_i) begin
                    state_q     <= LEAD;
                    div_q       <= bus.div_i;
                    hp_q        <= bus.div_i;
                    cpha_q      <= bus.cpha_i;
                    lsb_q       <= bus.lsb_i;
                    nb_q        <= nb_in;
                    tx_q        <= bus.tx_data_i;
                    rx_q        <= '0;
                    half_q      <= '0;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                    sck_q       <= bus.cpol_i;
                    nss_q       <= nss_sel;
                    mosi_q      <= bus.cpha_i ? 1'b0 : first_bit;
`ifdef SPI_RX_BYTE_REV_EN
                    rev_q       <= bus.rev_i;
`endif
                end
                LEAD: begin
                    if (hp_end) begin
                        hp_q    <= div_q;
                        state_q <= SHIFT;
                    end else begin
                        hp_q <= hp_q - 8'd1;
                    end
                end
                SHIFT: begin
                    if (hp_end) begin
                        hp_q  <= div_q;
                        sck_q <= ~sck_q;
                        // Sample edge is leading for cpha=0, trailing for cpha=1; the other edge shifts.
                        if (lead_edge ^ cpha_q)
                            rx_q[bit_pos(lsb_q, nbits, bidx)] <= bus.spi_miso_i;
                        else if (cpha_q)
                            mosi_q <= tx_q[bit_pos(lsb_q, nbits, bidx)];
                        else if (bnext < nbits)
                            mosi_q <= tx_q[bit_pos(lsb_q, nbits, bnext)];
                        if (last_half)
                            state_q <= TRAIL;
                        else
                            half_q <= half_q + HW'(1);
                    end else begin
                        hp_q <= hp_q - 8'd1;
                    end
                end
                TRAIL: begin
                    if (hp_end) begin
                        nss_q   <= '1;
                        state_q <= RESP;
                    end else begin
                        hp_q <= hp_q - 8'd1;
                    end
                end
                RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rx_out_q    <= rx_final;
                    end else if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rx_data_o   = rx_out_q;
    assign bus.busy_o      = busy_q;
    assign bus.spi_sck_o   = sck_q;
    assign bus.spi_nss_o   = nss_q;
    assign bus.spi_mosi_o  = mosi_q;
endmodule

// File: tb/tb_spi_xfer_engine.sv
// Bench for spi_xfer_engine: an SPI slave model drives MISO from a per-transfer word and
// records MOSI at each sample edge; results are compared against word-level expectations.
module tb_spi_xfer_engine;
    localparam int MB = 4;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_engine_if #(.MAX_BYTES(MB), .NUM_CS(NC)) bus ();
    spi_xfer_engine #(.MAX_BYTES(MB), .NUM_CS(NC)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          c_div, c_nb, c_cs;
    bit          c_cpol, c_cpha, c_lsb, c_rev;
    logic [31:0] c_tx, c_stream;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nbits();
        return 8 * (c_nb + 1);
    endfunction

    function automatic int pos(input int k);
        return c_lsb ? k : nbits() - 1 - k;
    endfunction

    function automatic logic [31:0] active(input logic [31:0] v);
        return (c_nb == 3) ? v : (v & ((32'd1 << nbits()) - 32'd1));
    endfunction

    function automatic logic [31:0] exp_rx();
        logic [31:0] v;
        logic [7:0]  q[$];
        v = active(c_stream);
`ifdef SPI_RX_BYTE_REV_EN
        if (c_rev) begin
            for (int k = 0; k <= c_nb; k++) q.push_back(v[8*k +: 8]);
            v = '0;
            for (int k = 0; k <= c_nb; k++) v[8*k +: 8] = q.pop_back();
        end
`endif
        return v;
    endfunction

    // Slave model: presents stream bit n until the n-th sample edge, records MOSI on sample edges.
    int          nsamp = 0;
    int          nrise = 0;
    logic [31:0] cap = '0;
    logic [NC-1:0] nss_mid = '1;
    logic        busy_d = 1'b0;
    logic        sck_d = 1'b0;
    always @(negedge clk) begin
        if (bus.busy_o && !busy_d) begin
            nsamp = 0; nrise = 0; cap = '0; nss_mid = '1;
        end else if (bus.busy_o && bus.spi_sck_o != sck_d) begin
            if (bus.spi_sck_o) nrise++;
            if ((sck_d == c_cpol) != c_cpha) begin
                if (nsamp == 0) nss_mid = bus.spi_nss_o;
                if (nsamp < nbits()) cap[pos(nsamp)] = bus.spi_mosi_o;
                nsamp++;
            end
        end
        bus.spi_miso_i = (nsamp < nbits()) ? c_stream[pos(nsamp)] : 1'b0;
        busy_d = bus.busy_o;
        sck_d  = bus.spi_sck_o;
    end

    task automatic rand_cfg();
        c_div    = $urandom_range(0, 3);
        c_cpol   = 1'($urandom_range(0, 1));
        c_cpha   = 1'($urandom_range(0, 1));
        c_lsb    = 1'($urandom_range(0, 1));
        c_nb     = $urandom_range(0, MB - 1);
        c_cs     = $urandom_range(0, NC - 1);
        c_tx     = $urandom;
        c_stream = $urandom;
        c_rev    = 1'($urandom_range(0, 1));
    endtask

    task automatic set_cfg(input int dv, input bit pol, input bit pha, input bit lsb,
                           input int nb, input int cs, input logic [31:0] tx,
                           input logic [31:0] st, input bit rv);
        c_div = dv; c_cpol = pol; c_cpha = pha; c_lsb = lsb;
        c_nb = nb; c_cs = cs; c_tx = tx; c_stream = st; c_rev = rv;
    endtask

    task automatic apply_req();
        bus.div_i     = 8'(c_div);
        bus.cpol_i    = c_cpol;
        bus.cpha_i    = c_cpha;
        bus.lsb_i     = c_lsb;
        bus.nbytes_i  = 2'(c_nb);
        bus.cs_sel_i  = 2'(c_cs);
        bus.tx_data_i = c_tx;
`ifdef SPI_RX_BYTE_REV_EN
        bus.rev_i     = c_rev;
`endif
        bus.req_valid_i = 1'b1;
    endtask

    task automatic scramble();
        bus.req_valid_i = 1'($urandom_range(0, 1));
        bus.div_i       = 8'($urandom);
        bus.cpol_i      = 1'($urandom_range(0, 1));
        bus.cpha_i      = 1'($urandom_range(0, 1));
        bus.lsb_i       = 1'($urandom_range(0, 1));
        bus.nbytes_i    = 2'($urandom);
        bus.cs_sel_i    = 2'($urandom);
        bus.tx_data_i   = $urandom;
`ifdef SPI_RX_BYTE_REV_EN
        bus.rev_i       = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic start_xfer(output int acc);
        @(negedge clk);
        apply_req();
        check_eq("req_ready_idle", bus.req_ready_o, 1);
        @(negedge clk);
        acc = cyc;
        check_eq("busy_on_accept", bus.busy_o, 1);
        check_eq("ready_low_busy", bus.req_ready_o, 0);
        check_eq("sck_lead_level", bus.spi_sck_o, c_cpol);
        if (!c_cpha) check_eq("mosi_first_bit", bus.spi_mosi_o, c_tx[pos(0)]);
        scramble();
    endtask

    task automatic wait_rsp(input int acc);
        logic [NC-1:0] e_nss;
        int n;
        n = 0;
        while (!bus.rsp_valid_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid_i = 1'b0;
        check_eq("rsp_timeout", bus.rsp_valid_o, 1);
        if (!bus.rsp_valid_o) return;
        e_nss = '1;
        e_nss[c_cs] = 1'b0;
        check_eq("latency", cyc - acc, (c_div + 1) * (2 * nbits() + 2) + 1);
        check_eq("rx_data", bus.rx_data_o, exp_rx());
        check_eq("mosi_stream", cap, active(c_tx));
        check_eq("sck_rises", nrise, nbits());
        check_eq("nss_active", nss_mid, e_nss);
        check_eq("nss_idle", bus.spi_nss_o, 4'hF);
        check_eq("sck_idle", bus.spi_sck_o, c_cpol);
    endtask

    task automatic consume(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("rsp_hold_valid", bus.rsp_valid_o, 1);
            check_eq("rsp_hold_data", bus.rx_data_o, exp_rx());
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check_eq("rsp_dropped", bus.rsp_valid_o, 0);
        check_eq("ready_back", bus.req_ready_o, 1);
        check_eq("busy_cleared", bus.busy_o, 0);
        check_eq("rx_held", bus.rx_data_o, exp_rx());
    endtask

    task automatic full_xfer(input int hold);
        int acc;
        start_xfer(acc);
        wait_rsp(acc);
        consume(hold);
    endtask

    initial begin
        int acc, n;
        logic [31:0] exp1;
        bit seen;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, '0, '0, 0);
        apply_req();
        bus.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", bus.req_ready_o, 1);
        check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
        check_eq("rst_busy", bus.busy_o, 0);
        check_eq("rst_sck", bus.spi_sck_o, 0);
        check_eq("rst_nss", bus.spi_nss_o, 4'hF);
        check_eq("rst_mosi", bus.spi_mosi_o, 0);
        check_eq("rst_rx", bus.rx_data_o, 0);
        rst = 1'b0;

        // Mode 0, fastest clock, one byte, cs 2
        set_cfg(0, 0, 0, 0, 0, 2, 32'hA5, 32'hA5, 0);
        full_xfer(0);
        check_eq("mode0_rx_const", bus.rx_data_o, 32'hA5);

        // Mode 3, div 3, four bytes LSB-first
        set_cfg(3, 1, 1, 1, 3, 1, 32'h12345678, 32'h12345678, 0);
        full_xfer(1);

        // Mode 1, MISO held high, two bytes
        set_cfg(1, 0, 1, 0, 1, 3, 32'hC3A1_5E0F, 32'hFFFF_FFFF, 0);
        full_xfer(0);
        check_eq("mode1_rx_const", bus.rx_data_o, 32'h0000FFFF);

        // Response back-pressure with a competing request pending
        set_cfg(1, 1, 0, 0, 2, 0, $urandom, $urandom, 0);
        start_xfer(acc);
        wait_rsp(acc);
        exp1 = exp_rx();
        set_cfg(0, 0, 1, 1, 1, 2, $urandom, $urandom, 0);
        @(negedge clk);
        apply_req();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_valid", bus.rsp_valid_o, 1);
            check_eq("bp_data", bus.rx_data_o, exp1);
            check_eq("bp_not_ready", bus.req_ready_o, 0);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        check_eq("bp_rsp_dropped", bus.rsp_valid_o, 0);
        check_eq("bp_ready_back", bus.req_ready_o, 1);
        @(negedge clk);
        acc = cyc;
        check_eq("bp_accept_busy", bus.busy_o, 1);
        check_eq("bp_accept_ready", bus.req_ready_o, 0);
        scramble();
        wait_rsp(acc);
        consume(0);

        // Reset in the middle of SHIFT
        set_cfg(1, 0, 0, 0, 1, 1, $urandom, $urandom, 0);
        start_xfer(acc);
        n = 0;
        while (nsamp < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("abort_nss", bus.spi_nss_o, 4'hF);
        check_eq("abort_sck", bus.spi_sck_o, 0);
        check_eq("abort_busy", bus.busy_o, 0);
        check_eq("abort_rsp", bus.rsp_valid_o, 0);
        check_eq("abort_ready", bus.req_ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.rsp_valid_o) seen = 1'b1;
        end
        check_eq("abort_no_rsp", seen, 0);
        set_cfg(0, 1, 0, 1, 0, 0, $urandom, $urandom, 0);
        full_xfer(0);

`ifdef SPI_RX_BYTE_REV_EN
        set_cfg(0, 0, 0, 0, 2, 0, 32'h00AABBCC, 32'h00AABBCC, 1);
        full_xfer(0);
        check_eq("rev_rx_const", bus.rx_data_o, 32'h00CCBBAA);
`endif

        for (int t = 0; t < 25; t++) begin
            rand_cfg();
            full_xfer($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
